// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit per cycle; signed operands are divided as magnitudes and sign-corrected at completion.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              cancel,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [2*DATA_W-1:0]   work_r, work_s;
  logic [DATA_W-1:0]     divisor_r;
  logic                  neg_q_r, neg_rem_r;
  logic                  accept_s, zero_div_s;
  logic [DATA_W-1:0]     mag_a_s, mag_b_s, q_fin_s, r_fin_s;
  logic [DATA_W:0]       trial_s;

  // Operand magnitudes, one restoring step and the sign-corrected final result
  always_comb begin
    zero_div_s = (divisor == {DATA_W{1'b0}});
    mag_a_s    = (signed_div && dividend[DATA_W-1]) ? ((~dividend) + DATA_W'(1)) : dividend;
    mag_b_s    = (signed_div && divisor[DATA_W-1])  ? ((~divisor) + DATA_W'(1))  : divisor;
    trial_s    = work_r[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_r};
    if (!trial_s[DATA_W]) begin
      work_s = {trial_s[DATA_W-1:0], work_r[DATA_W-2:0], 1'b1};
    end else begin
      work_s = {work_r[2*DATA_W-2:0], 1'b0};
    end
    q_fin_s = neg_q_r   ? ((~work_s[DATA_W-1:0]) + DATA_W'(1)) : work_s[DATA_W-1:0];
    r_fin_s = neg_rem_r ? ((~work_s[2*DATA_W-1:DATA_W]) + DATA_W'(1)) : work_s[2*DATA_W-1:DATA_W];
  end

  // Next-state logic; cancel overrides everything but reset
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (cancel) begin
          state_s = IDLE;
        end else if (start) begin
          accept_s = 1'b1;
          state_s  = zero_div_s ? ZERO : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      ZERO:    state_s = cancel ? IDLE : DONE;
      CALC: begin
        if (cancel) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_W'(ITER - 1)) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, status flags and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      work_r    <= {(2*DATA_W){1'b0}};
      divisor_r <= {DATA_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ZERO) || (state_s == CALC);
      done    <= (state_s == DONE);
      if (accept_s) begin
        cnt_r     <= {CNT_W{1'b0}};
        // A zero divisor keeps the raw dividend, which becomes the remainder as-is
        work_r    <= {{DATA_W{1'b0}}, (zero_div_s ? dividend : mag_a_s)};
        divisor_r <= mag_b_s;
        neg_q_r   <= signed_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
        neg_rem_r <= signed_div && dividend[DATA_W-1];
      end else if (state_r == CALC) begin
        work_r <= work_s;
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Result registers change only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= {DATA_W{1'b0}};
      remainder   <= {DATA_W{1'b0}};
      div_by_zero <= 1'b0;
    end else if (state_r == CALC && state_s == DONE) begin
      quotient    <= q_fin_s;
      remainder   <= r_fin_s;
      div_by_zero <= 1'b0;
    end else if (state_r == ZERO && state_s == DONE) begin
      quotient    <= {DATA_W{1'b1}};
      remainder   <= work_r[DATA_W-1:0];
      div_by_zero <= 1'b1;
    end
  end

endmodule
